strobe_monitor: RTL and testbench

STROBE_MONITOR -- requirements
Module: strobe_monitor

---
 rtl/strobe_monitor_pkg.sv | 30 +++
 rtl/interval_counter.sv | 41 ++++
 rtl/strobe_monitor.sv | 142 ++++++++++++++
 tb/tb_strobe_monitor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/strobe_monitor_pkg.sv
// Shared types for the strobe monitor: FSM states and per-cycle interval classification.
package strobe_monitor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StLocked
  } state_e;

  typedef enum logic [1:0] {
    IvNone,
    IvGood,
    IvEarly,
    IvTimeout
  } interval_e;

  // The counter never runs past the late bound, so any event is either early or good.
  function automatic interval_e classify(logic event_seen, logic timeout,
                                         int unsigned interval, int unsigned min_good);
    interval_e cls;
    cls = IvNone;
    if (event_seen) begin
      cls = (interval < min_good) ? IvEarly : IvGood;
    end else if (timeout) begin
      cls = IvTimeout;
    end
    return cls;
  endfunction

endpackage

// File: rtl/interval_counter.sv
// Rising-edge detector plus interval counter that wraps at the late bound and flags timeouts.
module interval_counter #(
  parameter int unsigned MaxCount = 240,
  parameter int unsigned Width    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             strobe_i,
  output logic             event_o,
  output logic             timeout_o,
  output logic [Width-1:0] interval_o
);

  logic             strobe_q;
  logic [Width-1:0] count_q, count_d;
  logic             wrap;

  assign event_o    = strobe_i & ~strobe_q;
  assign interval_o = count_q + Width'(1);
  assign wrap       = (interval_o == Width'(MaxCount));
  assign timeout_o  = wrap & ~event_o;

  // Wrapping even without an event keeps the count bounded while the FSM idles.
  always_comb begin
    count_d = interval_o;
    if (event_o || wrap) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      strobe_q <= 1'b0;
      count_q  <= '0;
    end else begin
      strobe_q <= strobe_i;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/strobe_monitor.sv
// Periodic strobe monitor: acquires lock after consecutive good intervals, flywheels on misses.
module strobe_monitor
  import strobe_monitor_pkg::*;
#(
  parameter int unsigned PERIOD       = 240,
  parameter int unsigned TOLERANCE    = 0,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned LOSS_COUNT   = 2,
  parameter int unsigned SIZE_COUNTER = $clog2(PERIOD + TOLERANCE + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_strobe,
  output logic                    o_locked,
  output logic [SIZE_COUNTER-1:0] o_period,
  output logic                    o_err,
  output logic                    o_miss
);

  if (LOCK_COUNT < 1 || LOSS_COUNT < 1 || TOLERANCE >= PERIOD) begin : gen_param_check
    $error("strobe_monitor: need LOCK_COUNT>=1, LOSS_COUNT>=1 and TOLERANCE<PERIOD");
  end

  localparam int unsigned GoodW   = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BadW    = $clog2(LOSS_COUNT + 1);
  localparam int unsigned MinGood = PERIOD - TOLERANCE;

  logic                    ev, timeout;
  logic [SIZE_COUNTER-1:0] interval;
  interval_e               iv_class;

  state_e                  state_q, state_d;
  logic [GoodW-1:0]        good_q, good_d;
  logic [BadW-1:0]         bad_q, bad_d;
  logic                    locked_q, locked_d;
  logic [SIZE_COUNTER-1:0] period_q, period_d;
  logic                    err_q, err_d;
  logic                    miss_q, miss_d;

  interval_counter #(
    .MaxCount(PERIOD + TOLERANCE),
    .Width   (SIZE_COUNTER)
  ) u_interval_counter (
    .clk_i     (i_clk),
    .rst_ni    (i_reset_n),
    .strobe_i  (i_strobe),
    .event_o   (ev),
    .timeout_o (timeout),
    .interval_o(interval)
  );

  assign iv_class = classify(ev, timeout, 32'(interval), MinGood);

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    bad_d    = bad_q;
    period_d = period_q;
    err_d    = 1'b0;
    miss_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ev) begin
          state_d = StSearch;
          good_d  = '0;
        end
      end
      StSearch: begin
        case (iv_class)
          IvGood: begin
            period_d = interval;
            if (good_q == GoodW'(LOCK_COUNT - 1)) begin
              state_d = StLocked;
              good_d  = GoodW'(LOCK_COUNT);
              bad_d   = '0;
            end else begin
              good_d = good_q + GoodW'(1);
            end
          end
          IvEarly: begin
            period_d = interval;
            err_d    = 1'b1;
            good_d   = '0;
          end
          IvTimeout: begin
            miss_d  = 1'b1;
            state_d = StIdle;
          end
          default: ;
        endcase
      end
      StLocked: begin
        if (iv_class == IvGood) begin
          period_d = interval;
          bad_d    = '0;
        end else if (iv_class == IvEarly || iv_class == IvTimeout) begin
          // A timeout restarts the interval like an event, so lock survives isolated misses.
          err_d  = (iv_class == IvEarly);
          miss_d = (iv_class == IvTimeout);
          if (iv_class == IvEarly) begin
            period_d = interval;
          end
          if (bad_q == BadW'(LOSS_COUNT - 1)) begin
            bad_d   = BadW'(LOSS_COUNT);
            good_d  = '0;
            state_d = (iv_class == IvEarly) ? StSearch : StIdle;
          end else begin
            bad_d = bad_q + BadW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      good_q   <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
      period_q <= '0;
      err_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      locked_q <= locked_d;
      period_q <= period_d;
      err_q    <= err_d;
      miss_q   <= miss_d;
    end
  end

  assign o_locked = locked_q;
  assign o_period = period_q;
  assign o_err    = err_q;
  assign o_miss   = miss_q;

endmodule

// File: tb/tb_strobe_monitor.sv
// Bench for strobe_monitor: two instances (TOLERANCE 0 and 2) against a timestamp-based model.
module tb_strobe_monitor;

  localparam int unsigned W0 = $clog2(241);
  localparam int unsigned W1 = $clog2(243);
  localparam int MIdle = 0, MSearch = 1, MLocked = 2;
  localparam int LockN = 4, LossN = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic s0 = 1'b0, s1 = 1'b0;
  logic lk0, er0, ms0, lk1, er1, ms1;
  logic [W0-1:0] pd0;
  logic [W1-1:0] pd1;

  always #5 clk = ~clk;

  strobe_monitor #(
    .PERIOD(240), .TOLERANCE(0), .LOCK_COUNT(4), .LOSS_COUNT(2)
  ) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_strobe(s0),
    .o_locked(lk0), .o_period(pd0), .o_err(er0), .o_miss(ms0)
  );

  strobe_monitor #(
    .PERIOD(240), .TOLERANCE(2), .LOCK_COUNT(4), .LOSS_COUNT(2)
  ) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_strobe(s1),
    .o_locked(lk1), .o_period(pd1), .o_err(er1), .o_miss(ms1)
  );

  // Model: intervals are differences of absolute cycle timestamps.
  int unsigned m_per[2] = '{240, 240};
  int unsigned m_tol[2] = '{0, 2};
  int          m_state[2];
  int          m_good[2], m_bad[2];
  bit          m_prev[2];
  longint      m_ref[2];
  longint      now = 0;
  bit          e_locked[2], e_err[2], e_miss[2];
  int unsigned e_period[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, now, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = MIdle; m_good[k] = 0; m_bad[k] = 0; m_prev[k] = 0; m_ref[k] = now;
      e_locked[k] = 0; e_err[k] = 0; e_miss[k] = 0; e_period[k] = 0;
    end
  endtask

  task automatic model_lose(int k, int dest);
    m_bad[k]++;
    if (m_bad[k] == LossN) begin
      m_state[k] = dest;
      m_good[k] = 0;
    end
  endtask

  task automatic model_step(int k, bit s);
    bit     ev;
    longint iv;
    ev = s && !m_prev[k];
    m_prev[k] = s;
    e_err[k] = 0;
    e_miss[k] = 0;
    iv = now - m_ref[k];
    if (ev) begin
      if (m_state[k] == MIdle) begin
        m_state[k] = MSearch;
        m_good[k] = 0;
      end else begin
        e_period[k] = int'(iv);
        if (iv < longint'(m_per[k] - m_tol[k])) begin
          e_err[k] = 1;
          if (m_state[k] == MSearch) m_good[k] = 0;
          else model_lose(k, MSearch);
        end else if (m_state[k] == MSearch) begin
          m_good[k]++;
          if (m_good[k] == LockN) begin
            m_state[k] = MLocked;
            m_bad[k] = 0;
          end
        end else begin
          m_bad[k] = 0;
        end
      end
      m_ref[k] = now;
    end else if (m_state[k] != MIdle && iv == longint'(m_per[k] + m_tol[k])) begin
      e_miss[k] = 1;
      if (m_state[k] == MSearch) m_state[k] = MIdle;
      else model_lose(k, MIdle);
      m_ref[k] = now;
    end
    e_locked[k] = (m_state[k] == MLocked);
  endtask

  task automatic tick();
    @(posedge clk);
    now++;
    model_step(0, s0);
    model_step(1, s1);
    #1;
    chk("d0_locked", lk0, e_locked[0]);
    chk("d0_period", pd0, e_period[0]);
    chk("d0_err", er0, e_err[0]);
    chk("d0_miss", ms0, e_miss[0]);
    chk("d0_err_miss_excl", er0 & ms0, 0);
    chk("d1_locked", lk1, e_locked[1]);
    chk("d1_period", pd1, e_period[1]);
    chk("d1_err", er1, e_err[1]);
    chk("d1_miss", ms1, e_miss[1]);
    chk("d1_err_miss_excl", er1 & ms1, 0);
  endtask

  // Pulse of the given width, then low until 'gap' cycles have elapsed since the rise.
  task automatic send(int k, int gap, int width = 1);
    for (int i = 0; i < gap; i++) begin
      if (k == 0) s0 = (i < width);
      else s1 = (i < width);
      tick();
    end
    if (k == 0) s0 = 1'b0;
    else s1 = 1'b0;
  endtask

  // Asserts reset between clock edges and checks outputs clear without a clock.
  task automatic do_reset();
    s0 = 1'b0;
    s1 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_locked", {lk0, lk1}, 0);
    chk("rst_async_period", {pd0, pd1}, 0);
    chk("rst_async_err_miss", {er0, ms0, er1, ms1}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_held_outputs", {lk0, pd0, er0, ms0, lk1, pd1, er1, ms1}, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout cycle=%0d", now);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();

    // Lock acquisition: fifth pulse locks.
    repeat (4) send(0, 240);
    chk("not_locked_after_4", lk0, 0);
    s0 = 1'b1; tick(); s0 = 1'b0;
    chk("locked_after_5th", lk0, 1);
    chk("period_after_lock", pd0, 240);
    repeat (239) tick();

    // One early pulse while locked.
    send(0, 239);
    s0 = 1'b1; tick(); s0 = 1'b0;
    chk("early_err", er0, 1);
    chk("early_period", pd0, 239);
    chk("early_keeps_lock", lk0, 1);
    repeat (239) tick();
    repeat (2) send(0, 240);
    chk("recover_period", pd0, 240);
    chk("recover_lock", lk0, 1);

    // Randomised gaps and pulse widths.
    for (int i = 0; i < 14; i++) begin
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(200, 300)) : 240;
      send(0, n, int'($urandom_range(1, 3)));
    end

    // Strobe stops: two misses, then lock drops.
    repeat (6) send(0, 240);
    chk("relock_before_stop", lk0, 1);
    n = 0;
    repeat (500) begin tick(); n += int'(ms0); end
    chk("stop_miss_count", n, 2);
    chk("stop_unlocked", lk0, 0);

    // Strobe held high: one event, then flywheel misses until lock is lost.
    repeat (6) send(0, 240);
    s0 = 1'b1;
    n = 0;
    repeat (1000) begin tick(); n += int'(ms0); end
    s0 = 1'b0;
    chk("held_high_miss_count", n, 2);
    chk("held_high_unlocked", lk0, 0);

    // Reset mid-lock discards history.
    repeat (6) send(0, 240);
    chk("locked_before_reset", lk0, 1);
    do_reset();
    repeat (4) send(0, 240);
    chk("post_reset_not_locked", lk0, 0);
    s0 = 1'b1; tick(); s0 = 1'b0;
    chk("post_reset_locked", lk0, 1);
    repeat (239) tick();

    // Tolerance 2 instance: edge-of-window intervals and late timeout.
    repeat (5) send(1, 240);
    chk("tol_locked", lk1, 1);
    send(1, 238);
    send(1, 242);
    s1 = 1'b1; tick(); s1 = 1'b0;
    chk("tol_period_242", pd1, 242);
    chk("tol_no_err", er1, 0);
    chk("tol_still_locked", lk1, 1);
    repeat (241) tick();
    tick();
    chk("tol_timeout_miss", ms1, 1);
    chk("tol_period_held", pd1, 242);
    for (int i = 0; i < 10; i++) begin
      send(1, int'($urandom_range(236, 246)), int'($urandom_range(1, 2)));
    end
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
